// File: rtl/param_sync_memory_if.sv
// Write, read and clear-control signals of param_sync_memory, grouped for the master
// (requester) and slave (memory) sides.
interface param_sync_memory_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 2
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  clear;
  logic                  busy;
  logic                  clear_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clear,
    input  rd_data, rd_valid, busy, clear_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clear,
    output rd_data, rd_valid, busy, clear_done
  );
endinterface

// File: rtl/param_sync_memory.sv
// Synchronous memory with registered read, selectable read-during-write behaviour and a
// clear sequencer that writes CLEAR_VALUE to every word after reset or on request.
module param_sync_memory #(
  parameter int unsigned          DATA_WIDTH  = 4,
  parameter int unsigned          ADDR_WIDTH  = 2,
  parameter int unsigned          DEPTH       = 4,
  parameter int unsigned          RD_MODE     = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic                clock,
  input logic                reset,
  param_sync_memory_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   DepthW   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                  clear_done_q, clear_done_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic wr_in_range, rd_in_range, same_addr;

  assign wr_in_range = {1'b0, bus.wr_addr} < DepthW;
  assign rd_in_range = {1'b0, bus.rd_addr} < DepthW;
  assign same_addr   = bus.wr_en && (bus.wr_addr == bus.rd_addr);

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.clear) state_d = StClear;
      end
      StClear: begin
        if (clr_ptr_q == LastAddr) begin
          state_d      = StIdle;
          clr_ptr_d    = '0;
          clear_done_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
    endcase
  end

  // The sequencer owns the write port while clearing; user writes are dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = CLEAR_VALUE;
    end else if (bus.wr_en && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (state_q == StIdle && bus.rd_en) begin
      rd_valid_d = 1'b1;
      if (!rd_in_range) begin
        rd_data_d = '0;
      end else if (RD_MODE == 1 && same_addr) begin
        rd_data_d = bus.wr_data;
      end else begin
        rd_data_d = mem[bus.rd_addr];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StClear;
      clr_ptr_q    <= '0;
      clear_done_q <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      clear_done_q <= clear_done_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign bus.busy       = (state_q == StClear);
  assign bus.clear_done = clear_done_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;

endmodule
